// File: rtl/mpte_fetch_unit_if.sv
// Bus bundle for mpte_fetch_unit: pipeline input/output handshakes and the MPTE memory port.
// The slave modport is the fetch unit's view; master is the surrounding environment's view.
interface mpte_fetch_unit_if #(
    parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH = 32,
    parameter int unsigned MEMORY_DATA_WIDTH         = 64,
    parameter int unsigned MEMORY_ADDR_WIDTH         = 32
);
    logic                                                   stage_slave_valid;
    logic                                                   stage_slave_ready;
    logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]                   stage_slave_data;
    logic                                                   stage_slave_walk;
    logic                                                   stage_master_valid;
    logic                                                   stage_master_ready;
    logic [PIPELINE_SLAVE_DATA_WIDTH+MEMORY_DATA_WIDTH-1:0] stage_master_data;
    logic                                                   stage_master_error;
    logic                                                   memory_master_mem_req;
    logic                                                   memory_master_mem_gnt;
    logic                                                   memory_master_mem_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]                           memory_master_mem_addr;
    logic [MEMORY_DATA_WIDTH-1:0]                           memory_master_mem_rdata;
    logic [MEMORY_DATA_WIDTH-1:0]                           memory_master_mem_wdata;
    logic                                                   memory_master_mem_we;
    logic [MEMORY_DATA_WIDTH/8-1:0]                         memory_master_mem_be;
    logic                                                   memory_master_mem_error;

    modport slave (
        input  stage_slave_valid, stage_slave_data, stage_slave_walk, stage_master_ready,
        input  memory_master_mem_gnt, memory_master_mem_valid, memory_master_mem_rdata,
        input  memory_master_mem_error,
        output stage_slave_ready, stage_master_valid, stage_master_data, stage_master_error,
        output memory_master_mem_req, memory_master_mem_addr, memory_master_mem_wdata,
        output memory_master_mem_we, memory_master_mem_be
    );

    modport master (
        output stage_slave_valid, stage_slave_data, stage_slave_walk, stage_master_ready,
        output memory_master_mem_gnt, memory_master_mem_valid, memory_master_mem_rdata,
        output memory_master_mem_error,
        input  stage_slave_ready, stage_master_valid, stage_master_data, stage_master_error,
        input  memory_master_mem_req, memory_master_mem_addr, memory_master_mem_wdata,
        input  memory_master_mem_we, memory_master_mem_be
    );
endinterface

// File: rtl/mpte_fetch_unit.sv
// Walking-stage MPTE fetch: in-order transaction queue issuing up to MAX_OUTSTANDING memory reads,
// bypassing non-walking entries, with per-entry error and squash-on-flush.
module mpte_fetch_unit #(
    parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH = 32,
    parameter int unsigned MEMORY_DATA_WIDTH         = 64,
    parameter int unsigned MEMORY_ADDR_WIDTH         = 32,
    parameter int unsigned TRANSACTION_FIFO_DEPTH    = 4,
    parameter int unsigned MAX_OUTSTANDING           = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    mpte_fetch_unit_if.slave     bus,
    output logic [31:0]          walk_count_o,
    output logic [31:0]          bypass_count_o
);
    localparam int unsigned PSDW  = PIPELINE_SLAVE_DATA_WIDTH;
    localparam int unsigned MDW   = MEMORY_DATA_WIDTH;
    localparam int unsigned DEPTH = TRANSACTION_FIFO_DEPTH;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_ISSUE = 2'd1;
    localparam logic [1:0] WAIT_RESP  = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    logic [1:0]      state_q   [DEPTH];
    logic [PSDW-1:0] payload_q [DEPTH];
    logic            walk_q    [DEPTH];
    logic [MDW-1:0]  rdata_q   [DEPTH];
    logic            err_q     [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr, count;
    logic [OW-1:0] outstanding, out_next;
    logic          squash, full, empty;
    logic          accept, pop, gnt_fire;
    logic          iss_found, resp_found;
    logic [AW-1:0] iss_idx, resp_idx, scan_idx, head;

    assign count = wr_ptr - rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = rd_ptr[AW-1:0];

    // Oldest-first scan from the head: first WAIT_ISSUE is issued, first WAIT_RESP takes the response.
    always_comb begin
        iss_found  = 1'b0;
        iss_idx    = '0;
        resp_found = 1'b0;
        resp_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head + AW'(i);
            if (PW'(i) < count) begin
                if (!iss_found && state_q[scan_idx] == WAIT_ISSUE) begin
                    iss_found = 1'b1;
                    iss_idx   = scan_idx;
                end
                if (!resp_found && state_q[scan_idx] == WAIT_RESP) begin
                    resp_found = 1'b1;
                    resp_idx   = scan_idx;
                end
            end
        end
    end

    assign bus.stage_slave_ready       = !full && !squash;
    assign bus.stage_master_valid      = !empty && (state_q[head] == DONE);
    assign bus.stage_master_data       = {rdata_q[head], payload_q[head]};
    assign bus.stage_master_error      = bus.stage_master_valid && err_q[head];
    assign bus.memory_master_mem_req   = iss_found && (outstanding < OW'(MAX_OUTSTANDING));
    assign bus.memory_master_mem_addr  = payload_q[iss_idx][MEMORY_ADDR_WIDTH-1:0];
    assign bus.memory_master_mem_wdata = '0;
    assign bus.memory_master_mem_we    = 1'b0;
    assign bus.memory_master_mem_be    = '1;

    assign accept   = bus.stage_slave_valid && bus.stage_slave_ready && !flush_i;
    assign pop      = bus.stage_master_valid && bus.stage_master_ready && !flush_i;
    assign gnt_fire = bus.memory_master_mem_req && bus.memory_master_mem_gnt;
    assign out_next = outstanding + OW'(gnt_fire) - OW'(bus.memory_master_mem_valid);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstanding    <= '0;
            squash         <= 1'b0;
            walk_count_o   <= '0;
            bypass_count_o <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i]   <= IDLE;
                payload_q[i] <= '0;
                walk_q[i]    <= 1'b0;
                rdata_q[i]   <= '0;
                err_q[i]     <= 1'b0;
            end
        end else begin
            outstanding <= out_next;
            if (flush_i) begin
                // Reads already granted stay counted; squash absorbs their responses.
                squash <= (out_next != '0);
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= IDLE;
            end else begin
                squash <= squash && (out_next != '0);
                if (gnt_fire) state_q[iss_idx] <= WAIT_RESP;
                if (bus.memory_master_mem_valid && resp_found) begin
                    state_q[resp_idx] <= DONE;
                    rdata_q[resp_idx] <= bus.memory_master_mem_rdata;
                    err_q[resp_idx]   <= bus.memory_master_mem_error;
                end
                if (accept) begin
                    state_q[wr_ptr[AW-1:0]]   <= bus.stage_slave_walk ? WAIT_ISSUE : DONE;
                    payload_q[wr_ptr[AW-1:0]] <= bus.stage_slave_data;
                    walk_q[wr_ptr[AW-1:0]]    <= bus.stage_slave_walk;
                    rdata_q[wr_ptr[AW-1:0]]   <= '0;
                    err_q[wr_ptr[AW-1:0]]     <= 1'b0;
                    wr_ptr                    <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    state_q[head] <= IDLE;
                    rd_ptr        <= rd_ptr + PW'(1);
                    if (walk_q[head]) walk_count_o   <= walk_count_o + 32'd1;
                    else              bypass_count_o <= bypass_count_o + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mpte_fetch_unit.sv
// Randomized bench for mpte_fetch_unit: a transaction-level scoreboard predicts every handshake
// output, read address, result, error and counter cycle by cycle.
module tb_mpte_fetch_unit;
    localparam int unsigned PSDW  = 32;
    localparam int unsigned MDW   = 64;
    localparam int unsigned MAW   = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] walk_count_o, bypass_count_o;

    mpte_fetch_unit_if #(.PIPELINE_SLAVE_DATA_WIDTH(PSDW), .MEMORY_DATA_WIDTH(MDW),
                         .MEMORY_ADDR_WIDTH(MAW)) bus ();

    mpte_fetch_unit #(
        .PIPELINE_SLAVE_DATA_WIDTH(PSDW), .MEMORY_DATA_WIDTH(MDW), .MEMORY_ADDR_WIDTH(MAW),
        .TRANSACTION_FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus),
        .walk_count_o(walk_count_o), .bypass_count_o(bypass_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PSDW-1:0] payload;
        bit              walk;
        bit              granted;
        bit              done;
        logic [MDW-1:0]  rdata;
        bit              err;
    } txn_t;

    txn_t        mq[$];
    int unsigned m_out;
    bit          m_squash;
    logic [31:0] m_wcnt, m_bcnt;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.stage_slave_valid       = 1'b0;
        bus.stage_slave_data        = '0;
        bus.stage_slave_walk        = 1'b0;
        bus.stage_master_ready      = 1'b0;
        bus.memory_master_mem_gnt   = 1'b0;
        bus.memory_master_mem_valid = 1'b0;
        bus.memory_master_mem_rdata = '0;
        bus.memory_master_mem_error = 1'b0;
        flush_i                     = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_out    = 0;
        m_squash = 1'b0;
        m_wcnt   = '0;
        m_bcnt   = '0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_slave_ready", bus.stage_slave_ready, 1'b1);
        check_eq("rst_master_valid", bus.stage_master_valid, 1'b0);
        check_eq("rst_mem_req", bus.memory_master_mem_req, 1'b0);
        check_eq("rst_error", bus.stage_master_error, 1'b0);
        check_eq("rst_walk_count", walk_count_o, 32'd0);
        check_eq("rst_bypass_count", bypass_count_o, 32'd0);
        check_eq("mem_we", bus.memory_master_mem_we, 1'b0);
        check_eq("mem_wdata", bus.memory_master_mem_wdata, '0);
        check_eq("mem_be", bus.memory_master_mem_be, 8'hFF);
    endtask

    // One cycle, entered at a falling edge: check outputs, drive inputs, advance the model.
    task automatic step(input int unsigned pv, input int unsigned pw, input int unsigned pr,
                        input int unsigned pg, input int unsigned pe, input int unsigned pf);
        bit          exp_ready, exp_valid, exp_req, has_issue;
        int          iss = -1;
        bit          v, wk, mr, g, rsp, fl, acc, pop, gf;
        int unsigned out_next;
        for (int i = 0; i < mq.size(); i++)
            if (iss < 0 && mq[i].walk && !mq[i].granted) iss = i;
        has_issue = (iss >= 0);
        exp_ready = (mq.size() < DEPTH) && !m_squash;
        exp_valid = (mq.size() > 0) && mq[0].done;
        exp_req   = has_issue && (m_out < MAXO);

        check_eq("slave_ready", bus.stage_slave_ready, exp_ready);
        check_eq("master_valid", bus.stage_master_valid, exp_valid);
        check_eq("mem_req", bus.memory_master_mem_req, exp_req);
        if (exp_req) check_eq("mem_addr", bus.memory_master_mem_addr, mq[iss].payload[MAW-1:0]);
        if (exp_valid) begin
            check_eq("master_data", bus.stage_master_data, {mq[0].rdata, mq[0].payload});
            check_eq("master_error", bus.stage_master_error, mq[0].err);
        end
        check_eq("walk_count", walk_count_o, m_wcnt);
        check_eq("bypass_count", bypass_count_o, m_bcnt);

        v   = ($urandom_range(0, 99) < pv);
        wk  = ($urandom_range(0, 99) < pw);
        mr  = ($urandom_range(0, 99) < pr);
        g   = ($urandom_range(0, 99) < pg);
        fl  = ($urandom_range(0, 99) < pf);
        rsp = (m_out > 0) && ($urandom_range(0, 99) < pe);
        bus.stage_slave_valid       = v;
        bus.stage_slave_walk        = wk;
        bus.stage_slave_data        = $urandom;
        bus.stage_master_ready      = mr;
        bus.memory_master_mem_gnt   = g;
        bus.memory_master_mem_valid = rsp;
        bus.memory_master_mem_rdata = {$urandom, $urandom};
        bus.memory_master_mem_error = ($urandom_range(0, 3) == 0);
        flush_i                     = fl;

        acc = v && exp_ready && !fl;
        pop = exp_valid && mr && !fl;
        gf  = exp_req && g;
        out_next = m_out + (gf ? 1 : 0) - (rsp ? 1 : 0);

        if (rsp) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].walk && mq[i].granted && !mq[i].done) begin
                    mq[i].done  = 1'b1;
                    mq[i].rdata = bus.memory_master_mem_rdata;
                    mq[i].err   = bus.memory_master_mem_error;
                    break;
                end
            end
        end
        if (gf) mq[iss].granted = 1'b1;
        if (fl) begin
            mq.delete();
            m_squash = (out_next > 0);
        end else begin
            m_squash = m_squash && (out_next > 0);
            if (pop) begin
                if (mq[0].walk) m_wcnt = m_wcnt + 32'd1;
                else            m_bcnt = m_bcnt + 32'd1;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back('{payload: bus.stage_slave_data, walk: wk, granted: 1'b0,
                                    done: !wk, rdata: '0, err: 1'b0});
        end
        m_out = out_next;
        @(negedge clk);
    endtask

    task automatic run_phase(input int unsigned n, input int unsigned pv, input int unsigned pw,
                             input int unsigned pr, input int unsigned pg, input int unsigned pe,
                             input int unsigned pf);
        for (int unsigned c = 0; c < n; c++) step(pv, pw, pr, pg, pe, pf);
    endtask

    initial begin
        drive_idle();
        model_reset();
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        run_phase(200, 90, 0, 100, 100, 50, 0);    // bypass stream
        run_phase(400, 80, 50, 100, 100, 40, 0);   // mixed walk/bypass
        run_phase(400, 80, 100, 30, 50, 30, 0);    // walks with backpressure
        run_phase(400, 90, 50, 20, 80, 50, 0);     // queue frequently full
        run_phase(200, 100, 100, 100, 100, 5, 0);  // slow responses, outstanding cap
        run_phase(800, 70, 60, 70, 60, 40, 5);     // flushes interleaved

        // Reset while walks are in flight; pending responses are discarded with it.
        run_phase(20, 100, 100, 50, 100, 0, 0);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs();
        drive_idle();
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;

        run_phase(600, 80, 60, 60, 70, 40, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
